// File: rtl/uart_cfg.sv
// ----------------------------------------------------------------------------
// uart_cfg - parametrised full-duplex UART with an oversampled receiver,
// a small RX FIFO and sticky status flags.
//
// Parameters : CLK_FREQ, BAUD, OVS (ticks per bit, even, >= 4),
//              DATA_W (5..9), PARITY (0 none, 1 even, 2 odd),
//              STOP_BITS (1 or 2), FIFO_DEPTH (power of two, >= 2)
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous active-low reset
//   rx              serial input, idle high, asynchronous to clk
//   transmit        start request, sampled while working=0
//   tx_data         word to send, captured together with transmit
//   rx_read         pops the FIFO head when rx_valid=1
//   clear_interrupt clears all four sticky flags
//   tx              serial output, idle high
//   working         transmitter busy
//   rx_data         FIFO head, valid while rx_valid=1
//   rx_valid        FIFO not empty
//   rx_interrupt    sticky, set on every FIFO push
//   parity_err      sticky, received parity mismatch
//   frame_err       sticky, a stop bit sampled low
//   overrun         sticky, word arrived while the FIFO was full
// ----------------------------------------------------------------------------
module uart_cfg #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVS        = 16,
    parameter int DATA_W     = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              transmit,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              rx_read,
    input  logic              clear_interrupt,
    output logic              tx,
    output logic              working,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_interrupt,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * OVS);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W    = $clog2(OVS);
    localparam int BIT_W   = $clog2(DATA_W);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVS - 1);
    localparam logic [OS_W-1:0]  OS_HALF   = OS_W'(OVS / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);
    localparam logic             PAR_ODD   = (PARITY == 2);
    localparam bit               HAS_PAR   = (PARITY != 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // ------------------------------------------------------------------ tick
    logic [DIV_W-1:0] r_div_cnt;
    logic             w_tick;

    assign w_tick = (r_div_cnt == DIV_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_div_cnt <= '0;
        else if (w_tick) r_div_cnt <= '0;
        else             r_div_cnt <= r_div_cnt + 1'b1;
    end

    // -------------------------------------------------------------- transmit
    state_t            r_tx_state;
    logic [OS_W-1:0]   r_tx_os;
    logic [BIT_W-1:0]  r_tx_bit;
    logic              r_tx_stop;
    logic [DATA_W-1:0] r_tx_shift;
    logic              r_tx_par;
    logic              r_tx;
    logic              r_working;
    logic              w_tx_bit_end;

    assign w_tx_bit_end = w_tick && (r_tx_os == OS_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_state <= S_IDLE;
            r_tx_os    <= '0;
            r_tx_bit   <= '0;
            r_tx_stop  <= 1'b0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx       <= 1'b1;
            r_working  <= 1'b0;
        end else if (r_tx_state == S_IDLE) begin
            if (transmit) begin
                // The bit phase restarts here so the start bit is a full OVS ticks.
                r_tx_shift <= tx_data;
                r_tx_par   <= (^tx_data) ^ PAR_ODD;
                r_tx_os    <= '0;
                r_tx       <= 1'b0;
                r_working  <= 1'b1;
                r_tx_state <= S_START;
            end
        end else if (w_tx_bit_end) begin
            r_tx_os <= '0;
            case (r_tx_state)
                S_START: begin
                    r_tx       <= r_tx_shift[0];
                    r_tx_bit   <= '0;
                    r_tx_state <= S_DATA;
                end
                S_DATA: begin
                    if (r_tx_bit == BIT_LAST) begin
                        r_tx_stop <= 1'b0;
                        if (HAS_PAR) begin
                            r_tx       <= r_tx_par;
                            r_tx_state <= S_PARITY;
                        end else begin
                            r_tx       <= 1'b1;
                            r_tx_state <= S_STOP;
                        end
                    end else begin
                        r_tx       <= r_tx_shift[1];
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_bit   <= r_tx_bit + 1'b1;
                    end
                end
                S_PARITY: begin
                    r_tx       <= 1'b1;
                    r_tx_state <= S_STOP;
                end
                S_STOP: begin
                    if (r_tx_stop == STOP_LAST) begin
                        r_working  <= 1'b0;
                        r_tx_state <= S_IDLE;
                    end else begin
                        r_tx_stop <= 1'b1;
                    end
                end
                default: r_tx_state <= S_IDLE;
            endcase
        end else if (w_tick) begin
            r_tx_os <= r_tx_os + 1'b1;
        end
    end

    // --------------------------------------------------------------- receive
    logic              r_rx_meta;
    logic              r_rx_sync;
    logic              r_rx_prev;
    state_t            r_rx_state;
    logic [OS_W-1:0]   r_rx_os;
    logic [BIT_W-1:0]  r_rx_bit;
    logic              r_rx_stop;
    logic [DATA_W-1:0] r_rx_shift;
    logic              w_rx_fall;
    logic              w_rx_sample;
    logic              w_push;
    logic              w_par_bad;
    logic              w_stop_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_rx_fall   = r_rx_prev & ~r_rx_sync;
    // Start is re-checked half a bit in; every later sample is one bit after that.
    assign w_rx_sample = w_tick && (r_rx_state != S_IDLE) &&
                         (r_rx_os == ((r_rx_state == S_START) ? OS_HALF : OS_LAST));
    assign w_push      = w_rx_sample && (r_rx_state == S_STOP) && (r_rx_stop == STOP_LAST);
    assign w_par_bad   = w_rx_sample && (r_rx_state == S_PARITY) &&
                         (r_rx_sync != ((^r_rx_shift) ^ PAR_ODD));
    assign w_stop_bad  = w_rx_sample && (r_rx_state == S_STOP) && !r_rx_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_state <= S_IDLE;
            r_rx_os    <= '0;
            r_rx_bit   <= '0;
            r_rx_stop  <= 1'b0;
            r_rx_shift <= '0;
        end else if (r_rx_state == S_IDLE) begin
            if (w_rx_fall) begin
                r_rx_os    <= '0;
                r_rx_state <= S_START;
            end
        end else if (w_rx_sample) begin
            r_rx_os <= '0;
            case (r_rx_state)
                S_START: begin
                    r_rx_bit   <= '0;
                    r_rx_state <= r_rx_sync ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_W-1:1]};
                    if (r_rx_bit == BIT_LAST) begin
                        r_rx_stop  <= 1'b0;
                        r_rx_state <= HAS_PAR ? S_PARITY : S_STOP;
                    end else begin
                        r_rx_bit <= r_rx_bit + 1'b1;
                    end
                end
                S_PARITY: begin
                    r_rx_stop  <= 1'b0;
                    r_rx_state <= S_STOP;
                end
                S_STOP: begin
                    if (r_rx_stop == STOP_LAST) r_rx_state <= S_IDLE;
                    else                        r_rx_stop  <= 1'b1;
                end
                default: r_rx_state <= S_IDLE;
            endcase
        end else if (w_tick) begin
            r_rx_os <= r_rx_os + 1'b1;
        end
    end

    // ------------------------------------------------------------------ FIFO
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W:0]    r_wr_ptr;
    logic [PTR_W:0]    r_rd_ptr;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_wr;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_pop   = rx_read && !w_empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign w_wr    = w_push && (!w_full || w_pop);

    // NOTE: the storage array is reset because rx_data exposes the head
    // combinationally and must read 0 before the first word arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr[PTR_W-1:0]] <= r_rx_shift;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // ----------------------------------------------------------------- flags
    logic r_int;
    logic r_par_err;
    logic r_frm_err;
    logic r_ovr;

    // Set wins over clear when both happen in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_int     <= 1'b0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            if (w_wr)                          r_int     <= 1'b1;
            else if (clear_interrupt)          r_int     <= 1'b0;
            if (w_par_bad)                     r_par_err <= 1'b1;
            else if (clear_interrupt)          r_par_err <= 1'b0;
            if (w_stop_bad)                    r_frm_err <= 1'b1;
            else if (clear_interrupt)          r_frm_err <= 1'b0;
            if (w_push && w_full && !w_pop)    r_ovr     <= 1'b1;
            else if (clear_interrupt)          r_ovr     <= 1'b0;
        end
    end

    assign tx           = r_tx;
    assign working      = r_working;
    assign rx_data      = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign rx_valid     = !w_empty;
    assign rx_interrupt = r_int;
    assign parity_err   = r_par_err;
    assign frame_err    = r_frm_err;
    assign overrun      = r_ovr;

endmodule

// File: tb/tb_uart_cfg.sv
// ----------------------------------------------------------------------------
// tb_uart_cfg - scoreboard bench for uart_cfg.
// Three instances at 16 clocks per bit:
//   0: 8 data, even parity, 1 stop  (loopback or driven rx)
//   1: 8 data, no parity,   1 stop  (driven rx)
//   2: 7 data, odd parity,  2 stops (loopback)
// Stimulus pushes expected words into a per-instance queue that models a
// bounded FIFO; a monitor per instance pops and compares whenever rx_valid.
// ----------------------------------------------------------------------------
module tb_uart_cfg;

    localparam int DW [3] = '{8, 8, 7};
    localparam int PM [3] = '{1, 0, 2};
    localparam int SB [3] = '{1, 1, 2};
    localparam int BITCLK = 16;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic drv_rx [3];
    logic loop_en [3];
    logic trig [3];
    logic rd [3];
    logic clr [3];
    logic auto_rd [3];
    logic rx_in [3];
    logic tx_o [3];
    logic wk [3];
    logic vld [3];
    logic fint [3];
    logic fpe [3];
    logic ffe [3];
    logic fov [3];
    logic [8:0] rxd [3];

    logic [7:0] a_tx_data, b_tx_data, a_rx_data, b_rx_data;
    logic [6:0] c_tx_data, c_rx_data;

    assign rx_in[0] = loop_en[0] ? tx_o[0] : drv_rx[0];
    assign rx_in[1] = loop_en[1] ? tx_o[1] : drv_rx[1];
    assign rx_in[2] = loop_en[2] ? tx_o[2] : drv_rx[2];
    assign rxd[0]   = {1'b0, a_rx_data};
    assign rxd[1]   = {1'b0, b_rx_data};
    assign rxd[2]   = {2'b0, c_rx_data};

    uart_cfg #(.CLK_FREQ(1600000), .BAUD(100000), .OVS(16), .DATA_W(8),
               .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_a (
        .clk(clk), .rst(rst), .rx(rx_in[0]), .transmit(trig[0]), .tx_data(a_tx_data),
        .rx_read(rd[0]), .clear_interrupt(clr[0]), .tx(tx_o[0]), .working(wk[0]),
        .rx_data(a_rx_data), .rx_valid(vld[0]), .rx_interrupt(fint[0]),
        .parity_err(fpe[0]), .frame_err(ffe[0]), .overrun(fov[0]));

    uart_cfg #(.CLK_FREQ(1600000), .BAUD(100000), .OVS(16), .DATA_W(8),
               .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_b (
        .clk(clk), .rst(rst), .rx(rx_in[1]), .transmit(trig[1]), .tx_data(b_tx_data),
        .rx_read(rd[1]), .clear_interrupt(clr[1]), .tx(tx_o[1]), .working(wk[1]),
        .rx_data(b_rx_data), .rx_valid(vld[1]), .rx_interrupt(fint[1]),
        .parity_err(fpe[1]), .frame_err(ffe[1]), .overrun(fov[1]));

    uart_cfg #(.CLK_FREQ(1600000), .BAUD(100000), .OVS(16), .DATA_W(7),
               .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_c (
        .clk(clk), .rst(rst), .rx(rx_in[2]), .transmit(trig[2]), .tx_data(c_tx_data),
        .rx_read(rd[2]), .clear_interrupt(clr[2]), .tx(tx_o[2]), .working(wk[2]),
        .rx_data(c_rx_data), .rx_valid(vld[2]), .rx_interrupt(fint[2]),
        .parity_err(fpe[2]), .frame_err(ffe[2]), .overrun(fov[2]));

    // ------------------------------------------------------ reference model
    int checks   = 0;
    int failures = 0;
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q2[$];
    bit e_int [3];
    bit e_pe [3];
    bit e_fe [3];
    bit e_ov [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic qpush(input int i, input logic [8:0] v);
        case (i)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic qpop(input int i, output bit ok, output logic [8:0] v);
        ok = (qsize(i) != 0);
        v  = '0;
        if (ok) begin
            case (i)
                0:       v = q0.pop_front();
                1:       v = q1.pop_front();
                default: v = q2.pop_front();
            endcase
        end
    endtask

    // Line sequence of one frame, index 0 sent first; unused positions are idle.
    function automatic logic [15:0] frame_bits(input logic [8:0] d, input int dw, input int par,
                                               input int stops, input bit flip_par, input bit bad_stop);
        logic [15:0] f;
        int k;
        int ones;
        f = '1;
        k = 0;
        ones = 0;
        f[k] = 1'b0;
        k++;
        for (int b = 0; b < dw; b++) begin
            f[k] = d[b];
            if (d[b]) ones++;
            k++;
        end
        if (par != 0) begin
            f[k] = ((par == 1) ? (ones % 2 == 1) : (ones % 2 == 0)) ^ flip_par;
            k++;
        end
        for (int s = 0; s < stops; s++) begin
            f[k] = !bad_stop;
            k++;
        end
        return f;
    endfunction

    function automatic int frame_len(input int i);
        return 1 + DW[i] + ((PM[i] != 0) ? 1 : 0) + SB[i];
    endfunction

    function automatic logic [8:0] mask(input int i, input logic [8:0] d);
        return d & 9'((1 << DW[i]) - 1);
    endfunction

    // A word arriving into a full FIFO is lost and raises overrun.
    task automatic model_push(input int i, input logic [8:0] d, input bit pe, input bit fe);
        if (qsize(i) >= DEPTH) begin
            e_ov[i] = 1'b1;
        end else begin
            qpush(i, mask(i, d));
            e_int[i] = 1'b1;
        end
        if (pe && PM[i] != 0) e_pe[i] = 1'b1;
        if (fe)               e_fe[i] = 1'b1;
    endtask

    // ----------------------------------------------------------- monitors
    task automatic monitor(input int i);
        bit ok;
        logic [8:0] exp;
        forever begin
            @(negedge clk);
            if (auto_rd[i] && vld[i]) begin
                qpop(i, ok, exp);
                if (!ok) check($sformatf("rx%0d_unexpected_word", i), 32'(vld[i]), 32'd0);
                else     check($sformatf("rx%0d_data", i), 32'(rxd[i]), 32'(exp));
                rd[i] = 1'b1;
                @(posedge clk);
                #1 rd[i] = 1'b0;
            end
        end
    endtask

    initial begin
        fork
            monitor(0);
            monitor(1);
            monitor(2);
        join_none
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit reached");
    end

    // ---------------------------------------------------------- stimulus
    task automatic set_txd(input int i, input logic [8:0] v);
        if (i == 0) a_tx_data = v[7:0];
        else        c_tx_data = v[6:0];
    endtask

    task automatic check_flags(input int i);
        check($sformatf("int%0d", i),   32'(fint[i]), 32'(e_int[i]));
        check($sformatf("perr%0d", i),  32'(fpe[i]),  32'(e_pe[i]));
        check($sformatf("ferr%0d", i),  32'(ffe[i]),  32'(e_fe[i]));
        check($sformatf("ovr%0d", i),   32'(fov[i]),  32'(e_ov[i]));
        check($sformatf("valid%0d", i), 32'(vld[i]),  32'(qsize(i) != 0));
    endtask

    task automatic clear_flags(input int i);
        @(negedge clk);
        clr[i] = 1'b1;
        @(posedge clk);
        #1 clr[i] = 1'b0;
        e_int[i] = 1'b0;
        e_pe[i]  = 1'b0;
        e_fe[i]  = 1'b0;
        e_ov[i]  = 1'b0;
    endtask

    // Transmit one word on a loopback instance and check every bit on the line,
    // the busy length, and (with noise) that a mid-frame request is ignored.
    task automatic send_tx(input int i, input logic [8:0] d, input bit noise);
        logic [15:0] f;
        int n;
        int cnt;
        int j;
        f = frame_bits(mask(i, d), DW[i], PM[i], SB[i], 1'b0, 1'b0);
        n = frame_len(i);
        model_push(i, d, 1'b0, 1'b0);
        @(negedge clk);
        set_txd(i, d);
        trig[i] = 1'b1;
        @(posedge clk);
        #1 trig[i] = 1'b0;
        cnt = 0;
        j = 0;
        while (j < 400) begin
            @(negedge clk);
            if (!wk[i]) break;
            cnt++;
            if (j % BITCLK == BITCLK / 2 && j / BITCLK < n)
                check($sformatf("tx%0d_bit%0d", i, j / BITCLK), 32'(tx_o[i]), 32'(f[j / BITCLK]));
            if (noise && j == 40) begin
                set_txd(i, ~d);
                trig[i] = 1'b1;
            end
            if (noise && j == 41) trig[i] = 1'b0;
            j++;
        end
        trig[i] = 1'b0;
        check($sformatf("tx%0d_busy_clocks", i), 32'(cnt), 32'(n * BITCLK));
        check($sformatf("tx%0d_idle", i), 32'(tx_o[i]), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    // Drive one frame onto rx of an instance, optionally corrupted.
    task automatic drive(input int i, input logic [8:0] d, input bit pe, input bit fe);
        logic [15:0] f;
        int n;
        f = frame_bits(mask(i, d), DW[i], PM[i], SB[i], pe, fe);
        n = frame_len(i);
        model_push(i, d, pe, fe);
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            drv_rx[i] = f[k];
            repeat (BITCLK) @(negedge clk);
        end
        drv_rx[i] = 1'b1;
        repeat (24) @(negedge clk);
    endtask

    initial begin
        logic [8:0] d;
        bit pe;
        int t;
        rst = 1'b0;
        a_tx_data = '0;
        b_tx_data = '0;
        c_tx_data = '0;
        for (int i = 0; i < 3; i++) begin
            drv_rx[i]  = 1'b1;
            loop_en[i] = (i != 1);
            trig[i]    = 1'b0;
            rd[i]      = 1'b0;
            clr[i]     = 1'b0;
            auto_rd[i] = 1'b1;
            e_int[i]   = 1'b0;
            e_pe[i]    = 1'b0;
            e_fe[i]    = 1'b0;
            e_ov[i]    = 1'b0;
        end
        repeat (3) @(negedge clk);

        // Reset state.
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_tx%0d", i), 32'(tx_o[i]), 32'd1);
            check($sformatf("rst_working%0d", i), 32'(wk[i]), 32'd0);
            check($sformatf("rst_rx_data%0d", i), 32'(rxd[i]), 32'd0);
            check_flags(i);
        end
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Loopback, even parity: fixed word with a mid-frame request, then random words.
        send_tx(0, 9'h0A5, 1'b1);
        check_flags(0);
        for (int k = 0; k < 4; k++) begin
            d = 9'($urandom);
            send_tx(0, d, 1'b0);
            check_flags(0);
        end

        // Driven rx, even parity: forced parity error, clear, then random corruption.
        loop_en[0] = 1'b0;
        drive(0, 9'h03C, 1'b1, 1'b0);
        check_flags(0);
        clear_flags(0);
        check_flags(0);
        for (int k = 0; k < 4; k++) begin
            d  = 9'($urandom);
            pe = 1'($urandom_range(0, 1));
            drive(0, d, pe, 1'b0);
            check_flags(0);
        end
        clear_flags(0);
        check_flags(0);

        // No parity: framing error.
        drive(1, 9'h055, 1'b0, 1'b1);
        check_flags(1);
        clear_flags(1);
        check_flags(1);

        // Overrun: five words with no reads, then drain.
        auto_rd[1] = 1'b0;
        for (int k = 1; k <= 5; k++) drive(1, 9'(k), 1'b0, 1'b0);
        check_flags(1);
        auto_rd[1] = 1'b1;
        t = 0;
        while (qsize(1) != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain1_remaining", 32'(qsize(1)), 32'd0);
        repeat (3) @(negedge clk);
        check_flags(1);
        clear_flags(1);
        check_flags(1);

        // Glitch on the start bit: nothing received, receiver still usable.
        @(negedge clk);
        drv_rx[1] = 1'b0;
        repeat (4) @(negedge clk);
        drv_rx[1] = 1'b1;
        repeat (40) @(negedge clk);
        check_flags(1);
        d = 9'($urandom);
        drive(1, d, 1'b0, 1'b0);
        check_flags(1);
        clear_flags(1);

        // Seven data bits, odd parity, two stop bits.
        send_tx(2, 9'h07F, 1'b0);
        check_flags(2);
        for (int k = 0; k < 2; k++) begin
            d = 9'($urandom);
            send_tx(2, d, 1'b1);
            check_flags(2);
        end

        // Asynchronous reset in the third data bit aborts the frame at once.
        @(negedge clk);
        c_tx_data = 7'($urandom);
        trig[2] = 1'b1;
        @(posedge clk);
        #1 trig[2] = 1'b0;
        repeat (56) @(negedge clk);
        check("c_busy_before_rst", 32'(wk[2]), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("c_rst_tx", 32'(tx_o[2]), 32'd1);
        check("c_rst_working", 32'(wk[2]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            e_int[i] = 1'b0;
            e_pe[i]  = 1'b0;
            e_fe[i]  = 1'b0;
            e_ov[i]  = 1'b0;
        end
        q0.delete();
        q1.delete();
        q2.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check_flags(2);
        check("c_rst_rx_data", 32'(rxd[2]), 32'd0);
        d = 9'($urandom);
        send_tx(2, d, 1'b0);
        check_flags(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cfg.md
Name: uart_cfg

Overview:
- Parametrised full-duplex UART: TX serialiser plus RX deserialiser with 16x-style oversampling, a configurable-depth RX FIFO and sticky error flags.
- Generalises the fixed 8-bit UART in data width, parity mode, stop-bit count, oversampling and baud.
- Adds glitch-rejecting start detection, frame/overrun detection and buffered reads.
- Sits between the top-level serial pins and the command/processing logic, as a drop-in replacement where buffering or non-8N1 framing is needed.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- OVS, 16, oversampling ticks per bit; must be even and >= 4.
- DATA_W, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
- STOP_BITS, 1, number of stop bits: 1 or 2.
- FIFO_DEPTH, 4, RX FIFO entries; power of two, >= 2.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst, input, 1, asynchronous active-low reset.
- rx, input, 1, serial input; idle high; asynchronous to clk.
- transmit, input, 1, start request; sampled only while working=0.
- tx_data, input, DATA_W, word to send; captured with transmit.
- rx_read, input, 1, pops the FIFO head when rx_valid=1.
- clear_interrupt, input, 1, clears rx_interrupt, parity_err, frame_err and overrun.
- tx, output, 1, serial output; idle high.
- working, output, 1, TX busy.
- rx_data, output, DATA_W, FIFO head; valid while rx_valid=1.
- rx_valid, output, 1, FIFO not empty.
- rx_interrupt, output, 1, sticky; set on every FIFO push.
- parity_err, output, 1, sticky; set when a received parity bit mismatches.
- frame_err, output, 1, sticky; set when any received stop bit samples low.
- overrun, output, 1, sticky; set when a word arrives while the FIFO is full.

Behaviour:
- Reset (rst=0, asynchronous): tx=1, working=0, rx_valid=0, rx_data=0, all flags 0, FIFO pointers 0, both FSMs IDLE, tick counter 0. Reset mid-frame aborts immediately; nothing partial is kept.
- Tick generator: free-running counter DIV=CLK_FREQ/(BAUD*OVS), rounded down, minimum 1. One-cycle tick every DIV clocks. TX and RX share the tick.
- One bit period is OVS ticks. Frame order: start(0), DATA_W bits LSB first, optional parity, STOP_BITS stop bits(1).
- Parity computation: even gives XOR of the data bits; odd gives its inverse.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
  - In IDLE, transmit=1 latches tx_data. The next cycle sets working=1, starts the start bit on tx and restarts the TX tick phase.
  - Each state holds tx for OVS ticks.
  - working drops in the cycle after the last stop-bit tick. A transmit in that same cycle starts the next frame, so back-to-back frames have no idle gap.
  - transmit while working=1 is ignored; the held word is not altered.
- RX input synchronisation: rx passes a 2-FF synchroniser. All RX logic uses the synchronised value.
- RX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
  - In IDLE, a falling edge enters START. At OVS/2 ticks the line is re-sampled: low continues; high returns to IDLE with no flag (glitch rejection).
  - Each later bit is sampled once, OVS ticks after the previous sample, i.e. at mid-bit.
  - Parity mismatch sets parity_err; the word is still pushed.
  - Any stop bit sampled 0 sets frame_err; the word is still pushed.
  - After the last stop sample the FSM returns to IDLE and can detect a new start on the next falling edge.
- FIFO:
  - Push happens in the cycle of the last stop sample.
  - Push while full: word dropped, overrun=1, contents unchanged.
  - Push and pop in the same cycle while full: pop is applied first, the push succeeds and overrun is not set.
  - rx_read while empty is ignored.
  - rx_data shows the head combinationally from the storage array; it holds 0 after reset until the first push.
- Sticky flags: set takes priority over clear_interrupt when both occur in the same cycle. clear_interrupt clears all four flags together. No flag affects the FSMs.

Test Plan:
- Sim parameters CLK_FREQ=1600000, BAUD=100000, OVS=16 give DIV=1 and 16 clocks per bit. Default DATA_W=8, FIFO_DEPTH=4.
- Loopback tx->rx, PARITY=1, send 0xA5 -> tx line 0,1,0,1,0,0,1,0,1, parity 0, stop 1. working high for exactly 176 clocks. rx_valid=1, rx_data=0xA5, rx_interrupt=1, parity_err=0.
- PARITY=1, drive 0x3C with parity bit 1 -> parity_err=1, rx_data=0x3C. Then clear_interrupt pulse -> all flags 0.
- PARITY=0, drive 0x55 with stop bit 0 -> frame_err=1, rx_data=0x55.
- Overrun: drive 0x01..0x05 with no reads -> overrun=1. Four rx_read pops return 0x01, 0x02, 0x03, 0x04, then rx_valid=0.
- Glitch: rx low for 4 clocks, then high -> no push, no flags; FSM back in IDLE.
- DATA_W=7, PARITY=2, STOP_BITS=2, send 0x7F -> parity bit 0 (seven ones, odd), two stop bits, working high for 176 clocks. Assert rst during the 3rd data bit of the next frame -> tx=1 and working=0 with no clock edge.
